id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline. It sits between the IF/ID and ID/EXE pipeline registers and contains four parts: the register file, the control unit, the condition checker, and the field extractor. Outputs are combinational and feed the ID/EXE register. The register file is written from the write-back stage.

## Interface
- No parameters.
- `clk`  in  1  clock; register-file writes occur on the rising edge.
- `rst`  in  1  synchronous, active-high reset; clears the register file.
- `flush`  in  1  squashes the decoded instruction.
- `freeze`  in  1  reserved; has no effect in this stage.
- `PCIn`  in  32  PC+4 from IF/ID.
- `instructionReg`  in  32  instruction from IF/ID.
- `writeBackEn`  in  1  register-file write enable.
- `destWB`  in  4  write address.
- `valueWB`  in  32  write data.
- `hazard`  in  1  stall bubble request from the hazard unit.
- `statusReg`  in  4  {N,Z,C,V} = bits [3:0].
- `S_UpdateSig`, `branch`, `memWriteEn`, `memReadEn`, `writeBackEnOut`  out  1 each  control signals.
- `exeCMD`  out  4  ALU command.
- `res1`, `res2`  out  32  operand values read from the register file.
- `PC`  out  32  equal to `PCIn`.
- `signedImm24`  out  24  `instr[23:0]`.
- `R_d`  out  4  `instr[15:12]`.
- `isImmidiate`  out  1  `instr[25]`.
- `shiftOperand`  out  12  `instr[11:0]`.

## Operation
Instruction fields:
- cond = [31:28]
- mode = [27:26]
- I = [25]
- opcode = [24:21]
- S = [20]
- Rn = [19:16]
- Rd = [15:12]
- Rm = [3:0]

Control unit, mode 00. `S_UpdateSig` = S. `writeBackEnOut` = 1 unless noted.
- MOV 1101 → exeCMD 0001
- MVN 1111 → 1001
- ADD 0100 → 0010
- ADC 0101 → 0011
- SUB 0010 → 0100
- SBC 0110 → 0101
- AND 0000 → 0110
- ORR 1100 → 0111
- EOR 0001 → 1000
- CMP 1010 → 0100, no write-back
- TST 1000 → 0110, no write-back
- Any other opcode → all controls 0, exeCMD 0000.

Control unit, mode 01 (exeCMD 0010):
- S=1 (LDR): memReadEn=1, writeBackEnOut=1, S_UpdateSig=1.
- S=0 (STR): memWriteEn=1.

Control unit, other modes:
- mode 10: branch=1, exeCMD 0000.
- mode 11: all controls 0.

Condition check against {N,Z,C,V}:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1110 = 1; 1111 = 0.

Bubble rule: if condition false, `hazard`=1, or `flush`=1, then force S_UpdateSig, branch, memWriteEn, memReadEn and writeBackEnOut to 0. Data and field outputs are unaffected.

Register file:
- 15 × 32-bit registers, R0–R14. Reading address 15 returns 0.
- `res1` = R[Rn].
- `res2` = R[Rd] when the decoded instruction is a store (mode 01, S=0, before the bubble rule); otherwise R[Rm].
- Write: rising `clk` with `writeBackEn`=1 and `destWB`≠15 sets R[destWB] ← `valueWB`. Writes to 15 are ignored.
- Bypass: while `writeBackEn`=1, a read whose address equals `destWB` returns `valueWB` combinationally.

## Timing
- All outputs are combinational from `instructionReg`, `PCIn`, `statusReg`, `hazard`, `flush`, the register contents and the bypass path. No internal pipeline register.
- Register-file write latency is one edge; same-cycle reads see the value via the bypass.
- Reset: on a rising edge with `rst`=1, all registers become 0. Reset has priority over a simultaneous write.
- Outputs during and after reset depend only on the current inputs; reads return 0 once reset has been applied.
- Undriven (X) `instructionReg` yields X outputs; no requirement applies.

## Structure
- Shared package holds the opcode constants, the exeCMD constants, the mode constants and the condition-code constants.
- Sub-modules: `register_file`, `control_unit`, `condition_check`; the top level does field slicing, `res2` address muxing and bubble gating.

## Test plan
- Reset, then instr 0xE3A00014 (MOV R0,#20) → exeCMD=0001, writeBackEnOut=1, isImmidiate=1, shiftOperand=0x014, R_d=0, other controls 0.
- Write R0=5 (`writeBackEn`=1, destWB=0, valueWB=5), then instr 0xE0A04000 (ADC R4,R0,R0) → exeCMD=0011, res1=5, res2=5, R_d=4. Check the bypass value in the write cycle as well.
- instr 0x03A00014 (MOVEQ) with statusReg=0000 → all controls 0; with statusReg=0100 → writeBackEnOut=1.
- instr 0xE5801000 (STR R1,[R0]) with R1=7 → memWriteEn=1, exeCMD=0010, res2=7. instr 0xE5901000 (LDR) → memReadEn=1, writeBackEnOut=1, S_UpdateSig=1.
- instr 0xEA000003 (B) → branch=1, signedImm24=0x000003. Raising `hazard` or `flush` → branch=0.
- instr 0xE1500001 (CMP R0,R1) → exeCMD=0100, S_UpdateSig=1, writeBackEnOut=0. Write to destWB=15 → reads of R15 remain 0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: modes, opcodes, ALU commands,
// condition codes and the bundled control-signal struct.
package id_stage_pkg;

    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       sUpdate;
        logic       branch;
        logic       memWrite;
        logic       memRead;
        logic       writeBack;
        logic [3:0] exeCmd;
    } ctrlSigs_t;

endpackage

// File: rtl/id_stage_condition_check.sv
// Evaluates the instruction condition field against the {N,Z,C,V} flags.
module condition_check
    import id_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] statusReg,
    output logic       condMet
);

    logic n, z, c, v;
    assign {n, z, c, v} = statusReg;

    // Condition table; the 1111 encoding never executes.
    always_comb begin
        condMet = 1'b0;
        case (cond)
            COND_EQ: condMet = z;
            COND_NE: condMet = !z;
            COND_CS: condMet = c;
            COND_CC: condMet = !c;
            COND_MI: condMet = n;
            COND_PL: condMet = !n;
            COND_VS: condMet = v;
            COND_VC: condMet = !v;
            COND_HI: condMet = c && !z;
            COND_LS: condMet = !c || z;
            COND_GE: condMet = (n == v);
            COND_LT: condMet = (n != v);
            COND_GT: condMet = !z && (n == v);
            COND_LE: condMet = z || (n != v);
            COND_AL: condMet = 1'b1;
            default: condMet = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage_control_unit.sv
// Decodes mode/opcode/S into the raw control bundle before condition gating.
module control_unit
    import id_stage_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       sBit,
    output ctrlSigs_t  ctrl
);

    // Per-mode decode; unknown data-processing opcodes collapse to all-zero.
    always_comb begin
        ctrl = '0;
        case (mode)
            MODE_ARITH: begin
                ctrl.sUpdate   = sBit;
                ctrl.writeBack = 1'b1;
                case (opcode)
                    OP_MOV:  ctrl.exeCmd = EXE_MOV;
                    OP_MVN:  ctrl.exeCmd = EXE_MVN;
                    OP_ADD:  ctrl.exeCmd = EXE_ADD;
                    OP_ADC:  ctrl.exeCmd = EXE_ADC;
                    OP_SUB:  ctrl.exeCmd = EXE_SUB;
                    OP_SBC:  ctrl.exeCmd = EXE_SBC;
                    OP_AND:  ctrl.exeCmd = EXE_AND;
                    OP_ORR:  ctrl.exeCmd = EXE_ORR;
                    OP_EOR:  ctrl.exeCmd = EXE_EOR;
                    OP_CMP: begin
                        ctrl.exeCmd    = EXE_SUB;
                        ctrl.writeBack = 1'b0;
                    end
                    OP_TST: begin
                        ctrl.exeCmd    = EXE_AND;
                        ctrl.writeBack = 1'b0;
                    end
                    default: ctrl = '0;
                endcase
            end
            MODE_MEM: begin
                ctrl.exeCmd = EXE_ADD;
                if (sBit) begin
                    ctrl.memRead   = 1'b1;
                    ctrl.writeBack = 1'b1;
                    ctrl.sUpdate   = 1'b1;
                end else begin
                    ctrl.memWrite  = 1'b1;
                end
            end
            MODE_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.exeCmd = EXE_NOP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_register_file.sv
// 15-entry register file (R0-R14) with write-back bypass; address 15 reads 0.
module register_file
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  readAddr1,
    input  logic [3:0]  readAddr2,
    input  logic        writeEn,
    input  logic [3:0]  writeAddr,
    input  logic [31:0] writeData,
    output logic [31:0] readData1,
    output logic [31:0] readData2
);

    logic [31:0] regs [0:14];

    // Reset clears every register and wins over a coincident write; R15 is never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn && (writeAddr != 4'd15)) begin
            regs[writeAddr] <= writeData;
        end
    end

    // Read port 1: R15 is hard zero, otherwise bypass the in-flight write.
    always_comb begin
        readData1 = '0;
        if (readAddr1 != 4'd15) begin
            if (writeEn && (writeAddr == readAddr1)) begin
                readData1 = writeData;
            end else begin
                readData1 = regs[readAddr1];
            end
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        readData2 = '0;
        if (readAddr2 != 4'd15) begin
            if (writeEn && (writeAddr == readAddr2)) begin
                readData2 = writeData;
            end else begin
                readData2 = regs[readAddr2];
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: field slicing, register reads, control decode and
// bubble gating. Entirely combinational apart from the register file.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic [31:0] PCIn,
    input  logic [31:0] instructionReg,
    input  logic        writeBackEn,
    input  logic [3:0]  destWB,
    input  logic [31:0] valueWB,
    input  logic        hazard,
    input  logic [3:0]  statusReg,
    output logic        S_UpdateSig,
    output logic        branch,
    output logic        memWriteEn,
    output logic        memReadEn,
    output logic        writeBackEnOut,
    output logic [3:0]  exeCMD,
    output logic [31:0] res1,
    output logic [31:0] res2,
    output logic [31:0] PC,
    output logic [23:0] signedImm24,
    output logic [3:0]  R_d,
    output logic        isImmidiate,
    output logic [11:0] shiftOperand
);

    logic [3:0] cond, opcode, rn, rd, rm, addr2;
    logic [1:0] mode;
    logic       sBit, isStore, condMet, bubble;
    ctrlSigs_t  rawCtrl;

    // freeze is accepted for interface compatibility but does nothing here.
    logic unusedFreeze;
    assign unusedFreeze = freeze;

    assign cond   = instructionReg[31:28];
    assign mode   = instructionReg[27:26];
    assign opcode = instructionReg[24:21];
    assign sBit   = instructionReg[20];
    assign rn     = instructionReg[19:16];
    assign rd     = instructionReg[15:12];
    assign rm     = instructionReg[3:0];

    assign PC           = PCIn;
    assign signedImm24  = instructionReg[23:0];
    assign R_d          = rd;
    assign isImmidiate  = instructionReg[25];
    assign shiftOperand = instructionReg[11:0];

    // A store needs Rd's value as the data to write, decided before any bubble.
    assign isStore = (mode == MODE_MEM) && !sBit;
    assign addr2   = isStore ? rd : rm;

    register_file uRegFile (
        .clk       (clk),
        .rst       (rst),
        .readAddr1 (rn),
        .readAddr2 (addr2),
        .writeEn   (writeBackEn),
        .writeAddr (destWB),
        .writeData (valueWB),
        .readData1 (res1),
        .readData2 (res2)
    );

    control_unit uCtrl (
        .mode   (mode),
        .opcode (opcode),
        .sBit   (sBit),
        .ctrl   (rawCtrl)
    );

    condition_check uCond (
        .cond      (cond),
        .statusReg (statusReg),
        .condMet   (condMet)
    );

    assign bubble = !condMet || hazard || flush;

    // Squash side-effecting controls on a bubble; exeCMD passes through untouched.
    always_comb begin
        S_UpdateSig    = rawCtrl.sUpdate   && !bubble;
        branch         = rawCtrl.branch    && !bubble;
        memWriteEn     = rawCtrl.memWrite  && !bubble;
        memReadEn      = rawCtrl.memRead   && !bubble;
        writeBackEnOut = rawCtrl.writeBack && !bubble;
        exeCMD         = rawCtrl.exeCmd;
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// instructions/writes checked against a behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, writeBackEn, hazard;
    logic [31:0] PCIn, instructionReg, valueWB;
    logic [3:0]  destWB, statusReg;
    logic        S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEnOut;
    logic [3:0]  exeCMD, R_d;
    logic [31:0] res1, res2, PC;
    logic [23:0] signedImm24;
    logic        isImmidiate;
    logic [11:0] shiftOperand;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelRegs [0:14];
    int exeOf [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    logic [8:0] ctrlObs;
    assign ctrlObs = {S_UpdateSig, branch, memWriteEn, memReadEn, writeBackEnOut, exeCMD};

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .PCIn(PCIn),
        .instructionReg(instructionReg), .writeBackEn(writeBackEn), .destWB(destWB),
        .valueWB(valueWB), .hazard(hazard), .statusReg(statusReg),
        .S_UpdateSig(S_UpdateSig), .branch(branch), .memWriteEn(memWriteEn),
        .memReadEn(memReadEn), .writeBackEnOut(writeBackEnOut), .exeCMD(exeCMD),
        .res1(res1), .res2(res2), .PC(PC), .signedImm24(signedImm24), .R_d(R_d),
        .isImmidiate(isImmidiate), .shiftOperand(shiftOperand)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refRead(logic [3:0] a);
        if (a == 4'd15) return 32'd0;
        if (writeBackEn && destWB == a) return valueWB;
        return modelRegs[a];
    endfunction

    // Returns {S,B,MW,MR,WB,exe[3:0]} from the architectural rules.
    function automatic logic [8:0] refCtrl(logic [31:0] ins, logic [3:0] st, logic hz, logic fl);
        logic n, z, c, v, base, ok, s;
        logic [4:0] sig;
        logic [3:0] exe;
        int e;
        {n, z, c, v} = st;
        case (ins[31:29])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        ok  = (ins[31:29] == 3'd7) ? ~ins[28] : (base ^ ins[28]);
        s   = ins[20];
        sig = 5'b0;
        exe = 4'd0;
        if (ins[27:26] == 2'b00) begin
            e = exeOf[ins[24:21]];
            if (e >= 0) begin
                exe = 4'(e);
                sig = {s, 3'b000, (ins[24:21] != 4'b1010 && ins[24:21] != 4'b1000)};
            end
        end else if (ins[27:26] == 2'b01) begin
            exe = 4'd2;
            sig = s ? 5'b10011 : 5'b00100;
        end else if (ins[27:26] == 2'b10) begin
            sig = 5'b01000;
        end
        if (!ok || hz || fl) sig = 5'b0;
        return {sig, exe};
    endfunction

    // Advance one clock, mirroring the register-file update in the model.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 15; i++) modelRegs[i] = 32'd0;
        end else if (writeBackEn && destWB != 4'd15) begin
            modelRegs[destWB] = valueWB;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        rst = 0; flush = 0; freeze = 0; hazard = 0; writeBackEn = 0;
        destWB = 0; valueWB = 0; statusReg = 0; PCIn = 32'h100;
        instructionReg = 32'hE3A00014;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1;
        tick();
        rst = 0; writeBackEn = 1; destWB = 3; valueWB = 32'hDEAD_BEEF;
        tick();
        writeBackEn = 0; rst = 1;
        tick();
        rst = 0; instructionReg = 32'hE0830000; // ADD R0,R3,R0
        #1;
        assertCount++;
        if (res1 !== 32'd0) begin
            failCount++;
            $display("FAIL reset_clear: res1=%h expected 00000000", res1);
        end
    endtask

    task automatic test_mov();
        instructionReg = 32'hE3A00014; PCIn = 32'h0000_1234;
        #1;
        assertCount++;
        if (ctrlObs !== 9'b00001_0001) begin
            failCount++;
            $display("FAIL mov_ctrl: got %b expected 000010001", ctrlObs);
        end
        assertCount++;
        if ({isImmidiate, shiftOperand, R_d, PC} !== {1'b1, 12'h014, 4'd0, 32'h0000_1234}) begin
            failCount++;
            $display("FAIL mov_fields: imm=%b shOp=%h rd=%h pc=%h", isImmidiate, shiftOperand, R_d, PC);
        end
    endtask

    task automatic test_write_bypass();
        instructionReg = 32'hE0A04000;
        writeBackEn = 1; destWB = 0; valueWB = 32'd5;
        #1;
        assertCount++;
        if (res1 !== 32'd5 || res2 !== 32'd5) begin
            failCount++;
            $display("FAIL bypass: res1=%h res2=%h expected 5/5", res1, res2);
        end
        tick();
        writeBackEn = 0; valueWB = 32'd99;
        #1;
        assertCount++;
        if ({ctrlObs, res1, res2, R_d} !== {9'b00001_0011, 32'd5, 32'd5, 4'd4}) begin
            failCount++;
            $display("FAIL adc_read: ctrl=%b res1=%h res2=%h rd=%h", ctrlObs, res1, res2, R_d);
        end
    endtask

    task automatic test_condition();
        instructionReg = 32'h03A00014; statusReg = 4'b0000;
        #1;
        assertCount++;
        if (ctrlObs[8:4] !== 5'b00000) begin
            failCount++;
            $display("FAIL moveq_false: ctrl=%b expected 00000xxxx", ctrlObs);
        end
        statusReg = 4'b0100;
        #1;
        assertCount++;
        if (ctrlObs !== 9'b00001_0001) begin
            failCount++;
            $display("FAIL moveq_true: ctrl=%b expected 000010001", ctrlObs);
        end
        statusReg = 4'b0000;
    endtask

    task automatic test_store_load();
        writeBackEn = 1; destWB = 1; valueWB = 32'd7;
        tick();
        writeBackEn = 0; valueWB = 0;
        instructionReg = 32'hE5801000;
        #1;
        assertCount++;
        if ({ctrlObs, res1, res2} !== {9'b00100_0010, 32'd5, 32'd7}) begin
            failCount++;
            $display("FAIL str: ctrl=%b res1=%h res2=%h expected 001000010/5/7", ctrlObs, res1, res2);
        end
        instructionReg = 32'hE5901000;
        #1;
        assertCount++;
        if ({ctrlObs, res2} !== {9'b10011_0010, 32'd5}) begin
            failCount++;
            $display("FAIL ldr: ctrl=%b res2=%h expected 100110010/5", ctrlObs, res2);
        end
    endtask

    task automatic test_branch();
        instructionReg = 32'hEA000003;
        #1;
        assertCount++;
        if ({ctrlObs, signedImm24} !== {9'b01000_0000, 24'h000003}) begin
            failCount++;
            $display("FAIL branch: ctrl=%b imm=%h expected 010000000/000003", ctrlObs, signedImm24);
        end
        hazard = 1;
        #1;
        assertCount++;
        if (branch !== 1'b0) begin
            failCount++;
            $display("FAIL branch_hazard: branch=%b expected 0", branch);
        end
        hazard = 0; flush = 1;
        #1;
        assertCount++;
        if (branch !== 1'b0) begin
            failCount++;
            $display("FAIL branch_flush: branch=%b expected 0", branch);
        end
        flush = 0;
    endtask

    task automatic test_cmp_r15();
        instructionReg = 32'hE1500001;
        #1;
        assertCount++;
        if ({ctrlObs, res1, res2} !== {9'b10000_0100, 32'd5, 32'd7}) begin
            failCount++;
            $display("FAIL cmp: ctrl=%b res1=%h res2=%h expected 100000100/5/7", ctrlObs, res1, res2);
        end
        instructionReg = 32'hE08F000F; // ADD R0,R15,R15
        writeBackEn = 1; destWB = 15; valueWB = 32'hFFFF_FFFF;
        #1;
        assertCount++;
        if (res1 !== 32'd0 || res2 !== 32'd0) begin
            failCount++;
            $display("FAIL r15_bypass: res1=%h res2=%h expected 0/0", res1, res2);
        end
        tick();
        writeBackEn = 0;
        #1;
        assertCount++;
        if (res1 !== 32'd0 || res2 !== 32'd0) begin
            failCount++;
            $display("FAIL r15_after: res1=%h res2=%h expected 0/0", res1, res2);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [8:0]  expCtrl;
        logic [3:0]  a2;
        for (int it = 0; it < 400; it++) begin
            ins = $urandom;
            if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
            if ($urandom_range(3, 0) == 0) ins[27:26] = 2'b01;
            instructionReg = ins;
            statusReg   = 4'($urandom);
            hazard      = ($urandom_range(7, 0) == 0);
            flush       = ($urandom_range(7, 0) == 0);
            rst         = ($urandom_range(49, 0) == 0);
            writeBackEn = ($urandom_range(1, 0) == 1);
            destWB      = 4'($urandom);
            valueWB     = $urandom;
            PCIn        = $urandom;
            #1;
            expCtrl = refCtrl(ins, statusReg, hazard, flush);
            a2 = (ins[27:26] == 2'b01 && !ins[20]) ? ins[15:12] : ins[3:0];
            assertCount++;
            if (ctrlObs !== expCtrl) begin
                failCount++;
                $display("FAIL rand_ctrl[%0d]: ins=%h st=%b got %b expected %b", it, ins, statusReg, ctrlObs, expCtrl);
            end
            assertCount++;
            if (res1 !== refRead(ins[19:16])) begin
                failCount++;
                $display("FAIL rand_res1[%0d]: got %h expected %h", it, res1, refRead(ins[19:16]));
            end
            assertCount++;
            if (res2 !== refRead(a2)) begin
                failCount++;
                $display("FAIL rand_res2[%0d]: got %h expected %h", it, res2, refRead(a2));
            end
            assertCount++;
            if ({PC, signedImm24, R_d, isImmidiate, shiftOperand} !==
                {PCIn, ins[23:0], ins[15:12], ins[25], ins[11:0]}) begin
                failCount++;
                $display("FAIL rand_fields[%0d]: pc=%h imm=%h rd=%h i=%b sh=%h", it, PC, signedImm24, R_d, isImmidiate, shiftOperand);
            end
            tick();
        end
        idleInputs();
    endtask

    initial begin
        for (int i = 0; i < 15; i++) modelRegs[i] = 32'd0;
        test_reset();
        test_mov();
        test_write_bypass();
        test_condition();
        test_store_load();
        test_branch();
        test_cmp_r15();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
